sqdiff_acc_pipe: RTL and testbench

SQDIFF_ACC_PIPE -- requirements
Module: sqdiff_acc_pipe

---
 rtl/sqdiff_acc_pipe.sv | 194 +++++++++++++++++++
 tb/tb_sqdiff_acc_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqdiff_acc_pipe.sv
// -----------------------------------------------------------------------------
// sqdiff_acc_pipe
//
// Four-stage pipelined squared-difference / squared-sum unit with a windowed
// accumulator.
//   S1: registers a, b, mode, in_valid
//   S2: registers the SIZEIN+1-bit signed pre-add (mode=1) or pre-sub (mode=0)
//   S3: registers the square of the S2 result
//   S4: registers sq_out and updates the window accumulator
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; overrides clear and ce
//   ce         pipeline clock enable; low freezes all pipeline/accumulator regs
//   in_valid   a, b, mode carry a sample this cycle
//   a, b       signed SIZEIN-bit operands
//   mode       0 = (a-b)^2, 1 = (a+b)^2
//   clear      restart the accumulation window (works even with ce low)
//   out_valid  sq_out holds a fresh result (forced low while ce is low)
//   sq_out     signed 2*SIZEIN+2-bit square
//   acc_valid  one-cycle pulse: acc_out holds a completed window sum
//   acc_out    unsigned ACCW-bit running window sum
//   acc_sat    current or just-completed window saturated
//
// Build option
//   SQDIFF_ACC_SAT_EN  when defined, accumulator overflow clamps to 2^ACCW-1
//                      and raises acc_sat; otherwise the sum wraps and
//                      acc_sat is tied low.
// -----------------------------------------------------------------------------
module sqdiff_acc_pipe #(
    parameter int SIZEIN = 16,
    parameter int ACCW   = 48,
    parameter int NSAMP  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic signed [SIZEIN-1:0]   a,
    input  logic signed [SIZEIN-1:0]   b,
    input  logic                       mode,
    input  logic                       clear,
    output logic                       out_valid,
    output logic signed [2*SIZEIN+1:0] sq_out,
    output logic                       acc_valid,
    output logic [ACCW-1:0]            acc_out,
    output logic                       acc_sat
);

    localparam int SQW  = 2*SIZEIN + 2;
    localparam int CNTW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NSAMP - 1);

    // Pipeline registers
    logic signed [SIZEIN-1:0] a_q, b_q;
    logic                     mode_q, v1_q;
    logic signed [SIZEIN:0]   pre_q, pre_d;
    logic                     v2_q;
    logic signed [SQW-1:0]    prod_q, prod_d;
    logic                     v3_q;
    logic signed [SQW-1:0]    sq_q;
    logic                     ov_q, av_q;

    // Accumulator state
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] sq_ext;
    logic            take;
    logic signed [SQW-1:0] pre_ext;

`ifdef SQDIFF_ACC_SAT_EN
    logic            sat_q, sat_d;
    logic [ACCW:0]   sum_w;     // extra MSB is the overflow flag
`else
    logic [ACCW-1:0] sum_w;
`endif

    // S2: explicit sign extension so the add/sub cannot overflow
    always_comb begin
        if (mode_q) begin
            pre_d = $signed({a_q[SIZEIN-1], a_q}) + $signed({b_q[SIZEIN-1], b_q});
        end else begin
            pre_d = $signed({a_q[SIZEIN-1], a_q}) - $signed({b_q[SIZEIN-1], b_q});
        end
    end

    // S3: square at full width; the result is always non-negative
    assign pre_ext = SQW'(pre_q);
    assign prod_d  = pre_ext * pre_ext;

    // S4 accumulator: the square is treated as unsigned and zero-extended
    assign sq_ext = ACCW'($unsigned(prod_q));
    assign take   = ce && v3_q;

`ifdef SQDIFF_ACC_SAT_EN
    assign sum_w = {1'b0, acc_q} + {1'b0, sq_ext};
`else
    assign sum_w = acc_q + sq_ext;
`endif

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
`ifdef SQDIFF_ACC_SAT_EN
        sat_d = sat_q;
`endif
        if (clear) begin
            // A sample landing in S4 together with clear is dropped here,
            // but still reaches sq_out.
            cnt_d = '0;
            acc_d = '0;
`ifdef SQDIFF_ACC_SAT_EN
            sat_d = 1'b0;
`endif
        end else if (take) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNTW'(1);
            if (cnt_q == '0) begin
                // First sample of a window overwrites the previous sum.
                acc_d = sq_ext;
`ifdef SQDIFF_ACC_SAT_EN
                sat_d = 1'b0;
`endif
            end else begin
`ifdef SQDIFF_ACC_SAT_EN
                if (sum_w[ACCW]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum_w[ACCW-1:0];
                end
`else
                acc_d = sum_w;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            v1_q   <= 1'b0;
            pre_q  <= '0;
            v2_q   <= 1'b0;
            prod_q <= '0;
            v3_q   <= 1'b0;
            sq_q   <= '0;
            ov_q   <= 1'b0;
            av_q   <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
`ifdef SQDIFF_ACC_SAT_EN
            sat_q  <= 1'b0;
`endif
        end else begin
            if (ce) begin
                a_q    <= a;
                b_q    <= b;
                mode_q <= mode;
                v1_q   <= in_valid;
                pre_q  <= pre_d;
                v2_q   <= v1_q;
                prod_q <= prod_d;
                v3_q   <= v2_q;
                ov_q   <= v3_q;
                if (v3_q) begin
                    sq_q <= prod_q;
                end
                av_q   <= v3_q && !clear && (cnt_q == LAST_CNT);
            end else if (clear) begin
                // A pending window pulse belongs to the abandoned window.
                av_q   <= 1'b0;
            end
            cnt_q <= cnt_d;
            acc_q <= acc_d;
`ifdef SQDIFF_ACC_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    // Held results are not re-announced while the pipeline is frozen.
    assign out_valid = ov_q & ce;
    assign acc_valid = av_q & ce;
    assign sq_out    = sq_q;
    assign acc_out   = acc_q;
`ifdef SQDIFF_ACC_SAT_EN
    assign acc_sat   = sat_q;
`else
    assign acc_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_sqdiff_acc_pipe.sv
// -----------------------------------------------------------------------------
// tb_sqdiff_acc_pipe
//
// Scoreboarded bench for sqdiff_acc_pipe (SIZEIN=16, ACCW=34, NSAMP=4).
// Stimulus pushes the expected square plus the index of the enabled clock
// edge that accepted it; the monitor pops on out_valid, checks value and
// latency, and runs a window-sum model of the accumulator.
// -----------------------------------------------------------------------------
module tb_sqdiff_acc_pipe;

    localparam int     SIZEIN = 16;
    localparam int     ACCW   = 34;
    localparam int     NSAMP  = 4;
    localparam longint ACCMAX = (longint'(1) <<< ACCW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, ce, in_valid, mode, clear;
    logic signed [SIZEIN-1:0]   a, b;
    logic                       out_valid, acc_valid, acc_sat;
    logic signed [2*SIZEIN+1:0] sq_out;
    logic [ACCW-1:0]            acc_out;

    sqdiff_acc_pipe #(
        .SIZEIN (SIZEIN),
        .ACCW   (ACCW),
        .NSAMP  (NSAMP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .sq_out    (sq_out),
        .acc_valid (acc_valid),
        .acc_out   (acc_out),
        .acc_sat   (acc_sat)
    );

    typedef struct {
        longint sq;
        int     tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   drv_ce_cnt = 0;
    int   mon_ce_cnt = 0;

    function automatic longint ref_sq(input logic signed [SIZEIN-1:0] x,
                                      input logic signed [SIZEIN-1:0] y,
                                      input logic m);
        longint d;
        d = m ? (longint'(x) + longint'(y)) : (longint'(x) - longint'(y));
        return d * d;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One call = the inputs for exactly one rising edge.
    task automatic step(input int r, input int c, input int v, input int m,
                        input int cl, input int aa, input int bb);
        @(negedge clk);
        rst      = (r != 0);
        ce       = (c != 0);
        in_valid = (v != 0);
        mode     = (m != 0);
        clear    = (cl != 0);
        a        = 16'(aa);
        b        = 16'(bb);
        if (r != 0) exp_q.delete();
        if (c != 0) drv_ce_cnt++;
        if (c != 0 && v != 0 && r == 0)
            exp_q.push_back('{sq: ref_sq(a, b, mode), tag: drv_ce_cnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick16();
        case ($urandom_range(0, 3))
            0:       return 32767;
            1:       return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Monitor / reference model
    initial begin : monitor
        longint sum;
        int     cnt;
        bit     sat;
        bit     exp_av;
        logic   c_rst, c_ce, c_clr;
        exp_t   e;
        sum = 0;
        cnt = 0;
        sat = 1'b0;
        forever begin
            @(posedge clk);
            c_rst = rst;
            c_ce  = ce;
            c_clr = clear;
            if (c_ce) mon_ce_cnt++;
            #1;
            if (c_rst) begin
                sum = 0;
                cnt = 0;
                sat = 1'b0;
                chk("rst_out_valid", longint'(out_valid), 0);
                chk("rst_acc_valid", longint'(acc_valid), 0);
                chk("rst_sq_out",    longint'(sq_out),    0);
                chk("rst_acc_out",   longint'(acc_out),   0);
                chk("rst_acc_sat",   longint'(acc_sat),   0);
            end else begin
                if (!c_ce) begin
                    chk("ce_low_out_valid", longint'(out_valid), 0);
                    chk("ce_low_acc_valid", longint'(acc_valid), 0);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out actual=out_valid sq_out=%0d required=no_output",
                                 sq_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sq_out",  longint'(sq_out), e.sq);
                        chk("latency", longint'(mon_ce_cnt), longint'(e.tag + 3));
                        exp_av = 1'b0;
                        if (c_clr) begin
                            sum = 0;
                            cnt = 0;
                            sat = 1'b0;
                        end else begin
                            exp_av = (cnt == NSAMP - 1);
                            if (cnt == 0) begin
                                sum = e.sq;
                                sat = 1'b0;
                            end else begin
                                sum = sum + e.sq;
`ifdef SQDIFF_ACC_SAT_EN
                                if (sum > ACCMAX) begin
                                    sum = ACCMAX;
                                    sat = 1'b1;
                                end
`else
                                sum = sum & ACCMAX;
`endif
                            end
                            cnt = (cnt + 1) % NSAMP;
                        end
                        chk("acc_out",   longint'(acc_out),   sum);
                        chk("acc_valid", longint'(acc_valid), longint'(exp_av));
                        chk("acc_sat",   longint'(acc_sat),   longint'(sat));
                        $display("out sq=%0d acc=%0d acc_valid=%0b acc_sat=%0b clear=%0b",
                                 sq_out, acc_out, acc_valid, acc_sat, c_clr);
                    end
                end else begin
                    if (c_clr) begin
                        sum = 0;
                        cnt = 0;
                        sat = 1'b0;
                    end
                    chk("idle_acc_valid", longint'(acc_valid), 0);
                    chk("acc_hold",       longint'(acc_out),   sum);
                    chk("acc_sat_hold",   longint'(acc_sat),   longint'(sat));
                end
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; mode = 1'b0; clear = 1'b0;
        a = '0; b = '0;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 7, 7);
        idle(2);

        // Single sample (5 - -3)^2 = 64
        step(0, 1, 1, 0, 0, 5, -3);
        idle(6);
        step(0, 1, 0, 0, 1, 0, 0);

        // Extremes back-to-back
        step(0, 1, 1, 0, 0, 32767, -32768);
        step(0, 1, 1, 1, 0, -32768, -32768);
        idle(6);
        step(0, 1, 0, 0, 1, 0, 0);

        // Five samples of 4 with window of 4
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 3, 1);
        idle(6);
        step(0, 1, 0, 0, 1, 0, 0);

        // Four maximal sums: saturates or wraps to 0 depending on build
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, -32768, -32768);
        idle(6);
        step(0, 1, 0, 0, 1, 0, 0);

        // ce low for three cycles after the second of three samples;
        // in_valid during ce-low must not be accepted
        step(0, 1, 1, 0, 0, 100, -20);
        step(0, 1, 1, 1, 0, -7, 300);
        step(0, 0, 1, 0, 0, 999, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 5, 5);
        step(0, 1, 1, 0, 0, 1234, -4321);
        idle(6);
        step(0, 1, 0, 0, 1, 0, 0);

        // clear exactly on the S4 edge of a sample, and clear while frozen
        step(0, 1, 1, 0, 0, 9, 2);
        step(0, 1, 1, 0, 0, 4, 1);
        idle(1);
        step(0, 1, 0, 0, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // rst after two of four window samples, then a fresh window of 4s
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 3, 1);
        step(0, 1, 1, 0, 0, 3, 1);
        idle(4);
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 3, 1);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1 : 0,
                 ($urandom_range(0, 7) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0) ? 1 : 0,
                 pick16(), pick16());
        end

        idle(8);
        @(posedge clk);
        #2;
        chk("queue_empty", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
